// File: rtl/exc_commit_if.sv
// Writeback-stage commit handshake seen by the commit-point exception arbiter.
interface exc_commit_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [14:0] wb_exc_vec;
  logic [31:0] wb_fetch_badv;
  logic [31:0] wb_mem_badv;
  logic        wb_is_ertn;
  logic        wb_is_idle;
  logic        wb_refetch;
  logic        wb_ready;

  modport master (
    output wb_valid, wb_pc, wb_exc_vec, wb_fetch_badv, wb_mem_badv,
           wb_is_ertn, wb_is_idle, wb_refetch,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_pc, wb_exc_vec, wb_fetch_badv, wb_mem_badv,
           wb_is_ertn, wb_is_idle, wb_refetch,
    output wb_ready
  );
endinterface

// File: rtl/exc_commit.sv
// Commit-point exception arbiter: classifies the committing instruction, emits
// one-cycle CSR event pulses, and holds flush / IDLE until the redirect settles.
module exc_commit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  exc_commit_if.slave        wb,
  input  logic               ie,
  input  logic [11:0]        lie,
  input  logic [11:0]        is,
  output logic               is_exc,
  output logic [5:0]         excode,
  output logic [8:0]         esubcode,
  output logic [31:0]        badvaddr,
  output logic [31:0]        csr_pc,
  output logic               is_ertn,
  output logic               is_fetch_again,
  output logic               is_idle,
  output logic               flush
);

  typedef enum logic [1:0] {RUN, IDLE, FLUSH} state_t;

  typedef struct packed {
    logic [5:0] code;
    logic [8:0] esub;
    logic [1:0] badv_sel;  // 0: none, 1: fetch address, 2: memory address
  } exc_cls_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  function automatic exc_cls_t exc_decode(input logic [14:0] vec);
    exc_cls_t   c;
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 14; i >= 0; i--)
      if (vec[i]) idx = 4'(i);
    c.esub     = 9'd0;
    c.badv_sel = (idx <= 4'd3) ? 2'd1 : ((idx >= 4'd8) ? 2'd2 : 2'd0);
    case (idx)
      4'd0:    c.code = 6'h08;
      4'd1:    c.code = 6'h3F;
      4'd2:    c.code = 6'h03;
      4'd3:    c.code = 6'h07;
      4'd4:    c.code = 6'h0D;
      4'd5:    c.code = 6'h0E;
      4'd6:    c.code = 6'h0B;
      4'd7:    c.code = 6'h0C;
      4'd8:    c.code = 6'h09;
      4'd9:    begin c.code = 6'h08; c.esub = 9'd1; end
      4'd10:   c.code = 6'h3F;
      4'd11:   c.code = 6'h01;
      4'd12:   c.code = 6'h02;
      4'd13:   c.code = 6'h04;
      4'd14:   c.code = 6'h07;
      default: c.code = 6'h00;
    endcase
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic        commit, int_pend;
  exc_cls_t    cls;
  logic        exc_p0, ertn_p0, fa_p0, idle_p0, vld_p0;
  logic [5:0]  code_p0;
  logic [8:0]  esub_p0;
  logic [31:0] badv_p0, pc_p0;
  logic        idle_p1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter only decrements while nonzero so it cannot wrap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (exc_p0 || ertn_p0 || fa_p0) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LAST;
        end else if (idle_p0) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (exc_p0) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // Stage p0: classify the committing instruction (or the IDLE wake-up interrupt)
  always_comb begin
    wb.wb_ready = (state_q == RUN);
    commit      = wb.wb_valid && (state_q == RUN);
    int_pend    = ie && (|(lie & is));
    cls         = exc_decode(wb.wb_exc_vec);
    exc_p0      = 1'b0;
    ertn_p0     = 1'b0;
    fa_p0       = 1'b0;
    idle_p0     = 1'b0;
    code_p0     = cls.code;
    esub_p0     = cls.esub;
    badv_p0     = (cls.badv_sel == 2'd1) ? wb.wb_fetch_badv :
                  (cls.badv_sel == 2'd2) ? wb.wb_mem_badv   : 32'd0;
    pc_p0       = wb.wb_pc;
    if (commit) begin
      if (int_pend) begin
        exc_p0  = 1'b1;
        code_p0 = 6'h00;
        esub_p0 = 9'd0;
        badv_p0 = 32'd0;
      end else if (|wb.wb_exc_vec) begin
        exc_p0  = 1'b1;
      end else if (wb.wb_is_ertn) begin
        ertn_p0 = 1'b1;
      end else if (wb.wb_refetch) begin
        fa_p0   = 1'b1;
      end else if (wb.wb_is_idle) begin
        idle_p0 = 1'b1;
      end
    end else if ((state_q == IDLE) && int_pend) begin
      // csr_pc still holds the IDLE instruction's pc latched at IDLE entry
      exc_p0  = 1'b1;
      code_p0 = 6'h00;
      esub_p0 = 9'd0;
      badv_p0 = 32'd0;
      pc_p0   = csr_pc;
    end
    vld_p0 = exc_p0 || ertn_p0 || fa_p0 || idle_p0;
  end

  // Stage p1: registered event pulses and held CSR data
  always_ff @(posedge clk) begin
    if (reset) begin
      is_exc         <= 1'b0;
      is_ertn        <= 1'b0;
      is_fetch_again <= 1'b0;
      idle_p1        <= 1'b0;
      excode         <= 6'd0;
      esubcode       <= 9'd0;
      badvaddr       <= 32'd0;
      csr_pc         <= 32'd0;
    end else begin
      is_exc         <= exc_p0;
      is_ertn        <= ertn_p0;
      is_fetch_again <= fa_p0;
      idle_p1        <= idle_p0;
      if (exc_p0) begin
        excode   <= code_p0;
        esubcode <= esub_p0;
        badvaddr <= badv_p0;
      end
      if (vld_p0) csr_pc <= pc_p0;
    end
  end

  assign is_idle = idle_p1;
  assign flush   = (state_q == FLUSH) || idle_p1;

endmodule

// File: tb/tb_exc_commit.sv
// Bench for exc_commit: directed table, reset/IDLE sequences, and random commits
// checked against a timing-level reference model.
module tb_exc_commit;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ie;
  logic [11:0] lie, is;
  logic        is_exc, is_ertn, is_fetch_again, is_idle, flush;
  logic [5:0]  excode;
  logic [8:0]  esubcode;
  logic [31:0] badvaddr, csr_pc;

  exc_commit_if wb();

  exc_commit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .wb(wb), .ie(ie), .lie(lie), .is(is),
    .is_exc(is_exc), .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr),
    .csr_pc(csr_pc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again),
    .is_idle(is_idle), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [14:0] vec;
    logic [31:0] fb, mb;
    logic        ertn, refetch, idle, ie;
    logic [11:0] lie, is;
  } stim_t;

  // kind: 0 none, 1 exception/interrupt, 2 ertn, 3 refetch, 4 idle
  typedef struct {
    stim_t       s;
    int          kind;
    logic [5:0]  code;
    logic [8:0]  esub;
    logic [31:0] badv;
  } vec_t;

  int exc_code_tbl [15] = '{'h08, 'h3F, 'h03, 'h07, 'h0D, 'h0E, 'h0B, 'h0C,
                            'h09, 'h08, 'h3F, 'h01, 'h02, 'h04, 'h07};

  int vectors = 0;
  int miscompares = 0;
  logic [5:0]  m_code;
  logic [8:0]  m_esub;
  logic [31:0] m_badv, m_pc;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cycle(input logic e, input logic r, input logic f, input logic i,
                           input logic fl, input logic rdy);
    chk("is_exc",         32'(is_exc),         32'(e));
    chk("is_ertn",        32'(is_ertn),        32'(r));
    chk("is_fetch_again", 32'(is_fetch_again), 32'(f));
    chk("is_idle",        32'(is_idle),        32'(i));
    chk("flush",          32'(flush),          32'(fl));
    chk("wb_ready",       32'(wb.wb_ready),    32'(rdy));
    chk("excode",         32'(excode),         32'(m_code));
    chk("esubcode",       32'(esubcode),       32'(m_esub));
    chk("badvaddr",       badvaddr,            m_badv);
    chk("csr_pc",         csr_pc,              m_pc);
  endtask

  function automatic stim_t st(input logic [31:0] pc, input logic [14:0] vec,
                               input logic [31:0] fb, input logic [31:0] mb,
                               input logic ertn, input logic refetch, input logic idle,
                               input logic ie_i, input logic [11:0] lie_i, input logic [11:0] is_i);
    stim_t s;
    s.valid = 1'b1; s.pc = pc; s.vec = vec; s.fb = fb; s.mb = mb;
    s.ertn = ertn; s.refetch = refetch; s.idle = idle;
    s.ie = ie_i; s.lie = lie_i; s.is = is_i;
    return s;
  endfunction

  task automatic add(input stim_t s, input int kind, input logic [5:0] code,
                     input logic [8:0] esub, input logic [31:0] badv);
    vec_t v;
    v.s = s; v.kind = kind; v.code = code; v.esub = esub; v.badv = badv;
    tbl.push_back(v);
  endtask

  // Reference classification straight from the priority rules.
  function automatic vec_t ref_model(input stim_t s);
    vec_t v;
    v.s = s; v.kind = 0; v.code = 6'h00; v.esub = 9'd0; v.badv = 32'd0;
    if (!s.valid) return v;
    if (s.ie && ((s.lie & s.is) != 12'd0)) begin
      v.kind = 1;
      return v;
    end
    if (s.vec != 15'd0) begin
      int k = 0;
      while (!s.vec[k]) k++;
      v.kind = 1;
      v.code = 6'(exc_code_tbl[k]);
      v.esub = (k == 9) ? 9'd1 : 9'd0;
      v.badv = (k < 4) ? s.fb : ((k >= 8) ? s.mb : 32'd0);
      return v;
    end
    if (s.ertn)         v.kind = 2;
    else if (s.refetch) v.kind = 3;
    else if (s.idle)    v.kind = 4;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    wb.wb_valid = s.valid;   wb.wb_pc = s.pc;       wb.wb_exc_vec = s.vec;
    wb.wb_fetch_badv = s.fb; wb.wb_mem_badv = s.mb;
    wb.wb_is_ertn = s.ertn;  wb.wb_refetch = s.refetch; wb.wb_is_idle = s.idle;
    ie = s.ie; lie = s.lie; is = s.is;
  endtask

  task automatic expect_tail(input int kind);
    if (kind >= 1 && kind <= 3) begin
      for (int c = 1; c < FC; c++) begin
        @(negedge clk); chk_cycle(0, 0, 0, 0, 1, 0);
      end
      @(negedge clk); chk_cycle(0, 0, 0, 0, 0, 1);
    end else if (kind == 4) begin
      @(negedge clk); chk_cycle(0, 0, 0, 0, 0, 0);
    end
  endtask

  // Apply one commit, check the T+1 event cycle, leave the bus idle.
  task automatic apply_commit(input vec_t v);
    drive(v.s);
    @(negedge clk);
    if (v.kind == 1) begin m_code = v.code; m_esub = v.esub; m_badv = v.badv; end
    if (v.kind != 0) m_pc = v.s.pc;
    chk_cycle(v.kind == 1, v.kind == 2, v.kind == 3, v.kind == 4, v.kind != 0, v.kind == 0);
    wb.wb_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    apply_commit(v);
    expect_tail(v.kind);
  endtask

  task automatic idle_wake(input int wait_cycles, input logic [31:0] idle_pc);
    ie = 1'b0;
    for (int c = 0; c < wait_cycles; c++) begin
      @(negedge clk); chk_cycle(0, 0, 0, 0, 0, 0);
    end
    ie = 1'b1; lie = 12'h800; is = 12'h800;
    @(negedge clk);
    m_code = 6'h00; m_esub = 9'd0; m_badv = 32'd0; m_pc = idle_pc;
    chk_cycle(1, 0, 0, 0, 1, 0);
    is = 12'h000;
    expect_tail(1);
  endtask

  task automatic reset_check();
    reset = 1'b1;
    @(negedge clk);
    m_code = 6'h00; m_esub = 9'd0; m_badv = 32'd0; m_pc = 32'd0;
    chk_cycle(0, 0, 0, 0, 0, 1);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s0, srand;
    vec_t  v;
    reset = 1'b1;
    s0 = st(32'd0, 15'd0, 32'd0, 32'd0, 0, 0, 0, 0, 12'd0, 12'd0);
    s0.valid = 1'b0;
    drive(s0);
    m_code = 6'h00; m_esub = 9'd0; m_badv = 32'd0; m_pc = 32'd0;
    @(negedge clk); @(negedge clk);
    chk_cycle(0, 0, 0, 0, 0, 1);
    reset = 1'b0;

    add(st(32'h1c000010, 15'h0100, 32'h1c000010, 32'h00000003, 0, 0, 0, 0, 12'h000, 12'h000), 1, 6'h09, 9'd0, 32'h00000003);
    add(st(32'h1c000020, 15'h0410, 32'h1c000020, 32'h00001234, 0, 0, 0, 1, 12'h800, 12'h800), 1, 6'h00, 9'd0, 32'h0);
    add(st(32'h1c000024, 15'h0410, 32'h1c000024, 32'h00001234, 0, 0, 0, 0, 12'h800, 12'h800), 1, 6'h0D, 9'd0, 32'h0);
    add(st(32'h1c000030, 15'h0200, 32'h1c000030, 32'hdeadbeef, 0, 0, 0, 0, 12'h000, 12'h000), 1, 6'h08, 9'd1, 32'hdeadbeef);
    add(st(32'h1c000034, 15'h0001, 32'h1c000035, 32'h00000777, 0, 0, 0, 0, 12'h000, 12'h000), 1, 6'h08, 9'd0, 32'h1c000035);
    add(st(32'h1c000040, 15'h0040, 32'h1c000040, 32'h00000555, 1, 0, 0, 0, 12'h000, 12'h000), 1, 6'h0B, 9'd0, 32'h0);
    add(st(32'h1c000044, 15'h0000, 32'h1c000044, 32'h00000555, 1, 0, 0, 0, 12'h000, 12'h000), 2, 6'h0B, 9'd0, 32'h0);
    add(st(32'h1c000048, 15'h0000, 32'h1c000048, 32'h0, 0, 1, 1, 0, 12'h000, 12'h000), 3, 6'h0B, 9'd0, 32'h0);
    add(st(32'h1c00004c, 15'h0002, 32'h0badf00c, 32'h0, 0, 0, 0, 0, 12'h000, 12'h000), 1, 6'h3F, 9'd0, 32'h0badf00c);
    add(st(32'h1c000050, 15'h4000, 32'h1c000050, 32'h80000010, 0, 0, 0, 0, 12'h000, 12'h000), 1, 6'h07, 9'd0, 32'h80000010);
    add(st(32'h1c000054, 15'h1000, 32'h1c000054, 32'h80000020, 0, 0, 0, 1, 12'h0ff, 12'h700), 1, 6'h02, 9'd0, 32'h80000020);
    add(st(32'h1c000058, 15'h0000, 32'h1c000058, 32'h0, 0, 0, 0, 1, 12'h0f0, 12'h00f), 0, 6'h02, 9'd0, 32'h0);
    foreach (tbl[i]) run_vec(tbl[i]);

    // IDLE, long wait, interrupt wake-up
    v.s = st(32'h1c000100, 15'd0, 32'h0, 32'h0, 0, 0, 1, 0, 12'h000, 12'h000);
    v.kind = 4; v.code = 6'h0; v.esub = 9'd0; v.badv = 32'h0;
    run_vec(v);
    idle_wake(20, 32'h1c000100);

    // Reset while in IDLE, then a plain commit with no event
    v.s.pc = 32'h1c000200;
    run_vec(v);
    reset_check();
    v.s = st(32'h1c000204, 15'd0, 32'h0, 32'h0, 0, 0, 0, 0, 12'h000, 12'h000);
    v.kind = 0;
    run_vec(v);

    // Reset in the first and in the second FLUSH cycle
    for (int n = 1; n <= 2; n++) begin
      v = tbl[0];
      apply_commit(v);
      if (n == 2) begin
        @(negedge clk); chk_cycle(0, 0, 0, 0, 1, 0);
      end
      reset_check();
      v.s = st(32'h1c000300, 15'd0, 32'h0, 32'h0, 0, 0, 0, 0, 12'h000, 12'h000);
      v.kind = 0;
      run_vec(v);
    end

    // Random commits against the reference model
    for (int it = 0; it < 300; it++) begin
      int r;
      srand.valid   = ($urandom_range(0, 9) != 0);
      srand.pc      = $urandom & 32'hfffffffc;
      srand.fb      = $urandom;
      srand.mb      = $urandom;
      r = $urandom_range(0, 3);
      if (r == 1)      srand.vec = 15'(1) << $urandom_range(0, 14);
      else if (r == 2) srand.vec = (15'(1) << $urandom_range(0, 14)) | (15'(1) << $urandom_range(0, 14));
      else             srand.vec = 15'd0;
      srand.ertn    = ($urandom_range(0, 3) == 0);
      srand.refetch = ($urandom_range(0, 3) == 0);
      srand.idle    = ($urandom_range(0, 3) == 0);
      srand.ie      = 1'($urandom);
      srand.lie     = 12'($urandom);
      srand.is      = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'd0;
      v = ref_model(srand);
      run_vec(v);
      if (v.kind == 4) idle_wake($urandom_range(0, 4), srand.pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
